// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for the Sobel window generator.
// Latency: none, wires only.
// Backpressure: valid/ready on both the pixel stream (s_*) and the window stream (m_*).
// Ports: s_valid/s_ready/s_data carry raster-order pixels into the block;
//        m_valid/m_ready/m_win/m_row/m_col/m_last carry 3x3 windows out of it.
// master = producer of pixels and consumer of windows; slave = the window generator.
interface sobel_window_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [9*DATA_WIDTH-1:0] m_win;
    logic [ADDR_WIDTH-1:0]   m_row;
    logic [ADDR_WIDTH-1:0]   m_col;
    logic                    m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_win, m_row, m_col, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_win, m_row, m_col, m_last
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Buffers three image rows and emits one zero-padded 3x3 window per pixel, raster order.
// Latency: window valid the cycle after the pixel that made it eligible is accepted.
// Backpressure: m_ready stall holds the window register; s_ready drops when row orow+2 would overwrite row orow-1.
// Ports: clk, rst (sync, active high), i_start (frame start pulse), o_busy (frame in progress),
//        o_done (one-cycle end-of-frame pulse), bus (slave side of sobel_window_gen_if).
module sobel_window_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    sobel_window_gen_if.slave bus
);
    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [31:0] W32 = 32'(IMAGE_WIDTH);
    localparam logic [31:0] H32 = 32'(IMAGE_HEIGHT);
    localparam logic [31:0] N32 = W32 * H32;
    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] H_LAST = ADDR_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] WR_COL_LAST = CW'(IMAGE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Input side: accepted-pixel count plus its (slot, column) write position.
    logic [ADDR_WIDTH-1:0] in_cnt;
    logic [CW-1:0]         wr_col;
    logic [1:0]            wr_slot;

    // Output side: centre of the next window to load; orow_slot tracks orow mod 3.
    logic [ADDR_WIDTH-1:0] orow;
    logic [ADDR_WIDTH-1:0] ocol;
    logic [1:0]            orow_slot;

    logic [DATA_WIDTH-1:0] line_buf [3][IMAGE_WIDTH];

    logic                    m_valid_q;
    logic [9*DATA_WIDTH-1:0] m_win_q;
    logic [ADDR_WIDTH-1:0]   m_row_q;
    logic [ADDR_WIDTH-1:0]   m_col_q;
    logic                    m_last_q;

    logic                    s_ready_c;
    logic                    pix_acc;
    logic                    win_elig;
    logic                    win_load;
    logic                    last_hs;
    logic [31:0]             ready_lim;
    logic [31:0]             need_cnt;
    logic [ADDR_WIDTH-1:0]   lr_row;
    logic [ADDR_WIDTH-1:0]   lr_col;
    logic [9*DATA_WIDTH-1:0] win_nxt;
    logic [1:0]              row_slot [3];
    logic [CW-1:0]           col_idx  [3];
    logic                    row_ok   [3];
    logic                    col_ok   [3];

    // Accept while the frame is incomplete and the incoming row would not clobber row orow-1.
    assign ready_lim = (32'(orow) + 32'd2) * W32;
    assign s_ready_c = (state == ST_RUN) && (32'(in_cnt) < N32) && (32'(in_cnt) < ready_lim);
    assign pix_acc   = bus.s_valid && s_ready_c;

    // A window is ready once its lower-right neighbour, clipped to the image, has arrived.
    // The clipping is what lets the last row and column drain without a flush phase.
    assign lr_row   = (orow >= H_LAST) ? H_LAST : orow + ADDR_WIDTH'(1);
    assign lr_col   = (ocol >= W_LAST) ? W_LAST : ocol + ADDR_WIDTH'(1);
    assign need_cnt = 32'(lr_row) * W32 + 32'(lr_col);
    assign win_elig = (state == ST_RUN) && (orow <= H_LAST) && (32'(in_cnt) > need_cnt);
    assign win_load = win_elig && (!m_valid_q || bus.m_ready);
    assign last_hs  = m_valid_q && bus.m_ready && m_last_q;

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_win   = m_win_q;
    assign bus.m_row   = m_row_q;
    assign bus.m_col   = m_col_q;
    assign bus.m_last  = m_last_q;

    // Window taps: rows orow-1..orow+1 live in slots (orow-1..orow+1) mod 3.
    always_comb begin
        win_nxt     = '0;
        row_slot[0] = (orow_slot == 2'd0) ? 2'd2 : orow_slot - 2'd1;
        row_slot[1] = orow_slot;
        row_slot[2] = (orow_slot == 2'd2) ? 2'd0 : orow_slot + 2'd1;
        col_idx[0]  = CW'(ocol - ADDR_WIDTH'(1));
        col_idx[1]  = CW'(ocol);
        col_idx[2]  = CW'(ocol + ADDR_WIDTH'(1));
        row_ok[0]   = (orow != '0);
        row_ok[1]   = 1'b1;
        row_ok[2]   = (orow < H_LAST);
        col_ok[0]   = (ocol != '0);
        col_ok[1]   = 1'b1;
        col_ok[2]   = (ocol < W_LAST);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (row_ok[i] && col_ok[j]) begin
                    win_nxt[DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = line_buf[row_slot[i]][col_idx[j]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (last_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Row storage has no reset: stale contents are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            line_buf[wr_slot][wr_col] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt    <= '0;
            wr_col    <= '0;
            wr_slot   <= '0;
            orow      <= '0;
            ocol      <= '0;
            orow_slot <= '0;
            m_valid_q <= 1'b0;
            m_win_q   <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            m_last_q  <= 1'b0;
        end else if (state == ST_IDLE && i_start) begin
            in_cnt    <= '0;
            wr_col    <= '0;
            wr_slot   <= '0;
            orow      <= '0;
            ocol      <= '0;
            orow_slot <= '0;
        end else if (state == ST_RUN) begin
            if (pix_acc) begin
                in_cnt <= in_cnt + ADDR_WIDTH'(1);
                if (wr_col == WR_COL_LAST) begin
                    wr_col  <= '0;
                    wr_slot <= (wr_slot == 2'd2) ? 2'd0 : wr_slot + 2'd1;
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            if (win_load) begin
                m_valid_q <= 1'b1;
                m_win_q   <= win_nxt;
                m_row_q   <= orow;
                m_col_q   <= ocol;
                m_last_q  <= (orow == H_LAST) && (ocol == W_LAST);
                if (ocol == W_LAST) begin
                    ocol      <= '0;
                    orow      <= orow + ADDR_WIDTH'(1);
                    orow_slot <= (orow_slot == 2'd2) ? 2'd0 : orow_slot + 2'd1;
                end else begin
                    ocol <= ocol + ADDR_WIDTH'(1);
                end
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end else begin
            // DONE and IDLE present idle values on the window stream.
            m_valid_q <= 1'b0;
            m_win_q   <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            m_last_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: expected windows come from a zero-padded frame lookup.
// Latency: n/a.
// Backpressure: m_ready optionally randomized; s_valid continuous or gapped.
module tb_sobel_window_gen;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [AW-1:0]   row;
        logic [AW-1:0]   col;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic i_start;
    logic o_busy;
    logic o_done;

    sobel_window_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sobel_window_gen #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t            exp_q[$];
    int              n_chk  = 0;
    int              n_fail = 0;
    int              frame [H][W];
    logic            spot_en  [H][W];
    logic [9*DW-1:0] spot_val [H][W];
    logic            rand_rdy = 1'b0;
    int              done_cnt = 0;
    int              wins_hs  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int px(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return frame[r][c];
    endfunction

    function automatic logic [9*DW-1:0] ref_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = DW'(px(r - 1 + i, c - 1 + j));
        return w;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int v [9];
        logic [9*DW-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(v[k]);
        return w;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_spots();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                spot_en[r][c]  = 1'b0;
                spot_val[r][c] = '0;
            end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = r * W + c;
        clear_spots();
        spot_en[0][0] = 1'b1; spot_val[0][0] = pack9(0, 0, 0, 0, 0, 1, 0, 5, 6);
        spot_en[2][2] = 1'b1; spot_val[2][2] = pack9(6, 7, 8, 11, 12, 13, 16, 17, 18);
        spot_en[4][4] = 1'b1; spot_val[4][4] = pack9(18, 19, 0, 23, 24, 0, 0, 0, 0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
        clear_spots();
    endtask

    // Pushes the whole frame's expected window sequence, then pulses i_start.
    task automatic start_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back('{win: ref_win(r, c), row: AW'(r), col: AW'(c),
                                  last: (r == H - 1 && c == W - 1)});
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic send_pixels(input bit gapped, input int stop_n);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_n && cyc < 3000) begin
            @(posedge clk); #1;
            bus.s_valid = !gapped || (cyc % 3 == 0);
            bus.s_data  = DW'(frame[idx / W][idx % W]);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1 bus.s_valid = 1'b0;
        if (idx < stop_n) check("send_timeout", 128'(idx), 128'(stop_n));
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int b  = 0;
        while (done_cnt == d0 && b < 1000) begin
            @(negedge clk);
            b++;
        end
        repeat (4) @(negedge clk);
        check("done_pulses", 128'(done_cnt - d0), 128'(1));
        check("win_count", 128'(wins_hs), 128'(N));
        check("queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_o_busy"},  128'(o_busy), 128'(0));
        check({tag, "_o_done"},  128'(o_done), 128'(0));
        check({tag, "_s_ready"}, 128'(bus.s_ready), 128'(0));
        check({tag, "_m_valid"}, 128'(bus.m_valid), 128'(0));
        check({tag, "_m_win"},   128'(bus.m_win), 128'(0));
        check({tag, "_m_row"},   128'(bus.m_row), 128'(0));
        check({tag, "_m_col"},   128'(bus.m_col), 128'(0));
        check({tag, "_m_last"},  128'(bus.m_last), 128'(0));
    endtask

    initial begin : ready_driver
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples at negedge; pops the scoreboard on each window handshake.
    initial begin : monitor
        int   acc, hs_prev, loaded, need, r, c;
        bit   mon_active, prev_pend, last_prev, last_now, hs_now, exp_rdy;
        logic [105:0] prev_snap;
        exp_t e;
        acc = 0; hs_prev = 0; mon_active = 0; prev_pend = 0; last_prev = 0; prev_snap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = 0; hs_prev = 0; mon_active = 0; prev_pend = 0; last_prev = 0;
            end else begin
                last_now = 0;
                if (o_done) done_cnt++;
                check("o_done", 128'(o_done), 128'(last_prev));
                if (last_prev) check("o_busy_at_done", 128'(o_busy), 128'(0));

                loaded  = wins_hs + int'(bus.m_valid);
                exp_rdy = mon_active && (acc < N) && (acc < (loaded / W + 2) * W);
                check("s_ready", 128'(bus.s_ready), 128'(exp_rdy));

                if (!mon_active) check("m_valid_idle", 128'(bus.m_valid), 128'(0));
                if (prev_pend)
                    check("hold", 128'({bus.m_valid, bus.m_win, bus.m_row, bus.m_col, bus.m_last}),
                          128'(prev_snap));

                if (bus.m_valid && !prev_pend && exp_q.size() > 0) begin
                    need = min2(int'(exp_q[0].row) + 1, H - 1) * W + min2(int'(exp_q[0].col) + 1, W - 1);
                    check("eligible", 128'((acc - hs_prev) > need), 128'(1));
                end

                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_window", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("window", 128'({bus.m_win, bus.m_row, bus.m_col, bus.m_last}), 128'(e));
                        r = int'(e.row);
                        c = int'(e.col);
                        if (spot_en[r][c]) check("spot", 128'(bus.m_win), 128'(spot_val[r][c]));
                        if (e.last) begin
                            last_now   = 1;
                            mon_active = 0;
                        end
                    end
                    wins_hs++;
                end

                hs_now = bus.s_valid && bus.s_ready;
                acc += int'(hs_now);
                if (i_start && !mon_active && !last_now && !last_prev) begin
                    mon_active = 1;
                    acc        = 0;
                    wins_hs    = 0;
                end
                hs_prev   = int'(hs_now);
                prev_pend = bus.m_valid && !bus.m_ready;
                prev_snap = {bus.m_valid, bus.m_win, bus.m_row, bus.m_col, bus.m_last};
                last_prev = last_now;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1; i_start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        clear_spots();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Ramp, continuous input, no output stalls.
        fill_ramp();
        start_frame();
        send_pixels(1'b0, N);
        wait_done();

        // Horizontal edge frame.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = (r < 3) ? 255 : 0;
        clear_spots();
        spot_en[2][1] = 1'b1; spot_val[2][1] = pack9(255, 255, 255, 255, 255, 255, 0, 0, 0);
        spot_en[3][0] = 1'b1; spot_val[3][0] = pack9(0, 255, 255, 0, 0, 0, 0, 0, 0);
        start_frame();
        send_pixels(1'b0, N);
        wait_done();

        // Random pixels with random output stalls.
        rand_rdy = 1'b1;
        fill_random();
        start_frame();
        send_pixels(1'b0, N);
        wait_done();
        rand_rdy = 1'b0;

        // Ramp again with one pixel offered every third cycle.
        fill_ramp();
        start_frame();
        send_pixels(1'b1, N);
        wait_done();

        // Pixels offered while idle, then a stray i_start mid-frame.
        @(posedge clk); #1 bus.s_valid = 1'b1; bus.s_data = 8'hA5;
        repeat (6) @(posedge clk);
        #1 bus.s_valid = 1'b0;
        fill_random();
        start_frame();
        fork
            send_pixels(1'b0, N);
            begin
                repeat (10) @(posedge clk);
                #1 i_start = 1'b1;
                @(posedge clk); #1 i_start = 1'b0;
            end
        join
        wait_done();

        // Reset after 12 pixels, then a fresh frame.
        fill_random();
        start_frame();
        send_pixels(1'b0, 12);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        fill_ramp();
        start_frame();
        send_pixels(1'b0, N);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel kernel. Accepts one frame of 8-bit pixels in raster order from the BRAM0 read engine through a valid/ready stream.
- Buffers three image rows and emits one zero-padded 3x3 neighbourhood per pixel position through a second valid/ready stream.
- Output is IMAGE_WIDTH*IMAGE_HEIGHT windows per frame, in raster order of the centre pixel, so the Sobel result image has the same size as the input.

Parameters:
DATA_WIDTH, 8, pixel width in bits
ADDR_WIDTH, 16, width of the row/column/count fields
IMAGE_WIDTH, 5, pixels per row (>=2)
IMAGE_HEIGHT, 5, rows per frame (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle pulse; starts a frame when idle
o_busy  output  1  high from accepted i_start until o_done
o_done  output  1  one-cycle pulse after the last window handshake
s_valid  input  1  input pixel valid
s_ready  output  1  block accepts a pixel this cycle
s_data  input  DATA_WIDTH  input pixel, raster order
m_valid  output  1  window valid
m_ready  input  1  downstream accepts window
m_win  output  9*DATA_WIDTH  window; slice [DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = pixel(row-1+i, col-1+j), i,j in 0..2
m_row  output  ADDR_WIDTH  centre row of the current window
m_col  output  ADDR_WIDTH  centre column of the current window
m_last  output  1  high with the window centred at (H-1, W-1)

Behaviour:
- Reset (and idle) values: o_busy=0, o_done=0, s_ready=0, m_valid=0, m_win=0, m_row=0, m_col=0, m_last=0. All counters clear. Buffer contents are don't-care.
- FSM states:
  - IDLE: i_start goes to RUN; clear in_cnt, orow, ocol.
  - RUN: after the m_last handshake, go to DONE.
  - DONE: assert o_done for one cycle, then go to IDLE.
- i_start is ignored outside IDLE.
- Line storage: 3 rows x IMAGE_WIDTH entries. Pixel k = (r, c) is written to slot [r mod 3][c] on each s_valid && s_ready. in_cnt counts accepted pixels, 0..W*H.
- s_ready = (state==RUN) && (in_cnt < W*H) && (in_cnt < (orow+2)*W). The second term prevents row orow+2 from overwriting row orow-1.
- Window (orow, ocol) becomes eligible when in_cnt > min(orow+1, H-1)*W + min(ocol+1, W-1), i.e. its lower-right neighbour (clipped to the image) has been received. There is no separate flush phase; the clipping lets the final row and column drain.
- Zero padding: any tap with row <0, row >H-1, col <0 or col >W-1 reads 0.
- Output register: when eligible and (!m_valid || m_ready), load m_win/m_row/m_col/m_last, set m_valid=1, and advance ocol (wraps to 0 at W-1, then orow+1).
  - If not eligible while m_ready, clear m_valid.
  - While m_valid && !m_ready, all m_* outputs are held stable.
- Throughput: one window per cycle when both streams are unstalled.
- Latency: the window is valid on the cycle after the pixel that made it eligible is accepted.
- Same-cycle write and read: a pixel accepted in cycle t is never needed by a window loaded in cycle t, because eligibility uses the registered in_cnt.
- o_busy falls in the same cycle o_done rises.
- Reset mid-frame: within one cycle all outputs return to reset values. Partial frame data is discarded and no o_done is produced.
- Pixels presented in IDLE or DONE are not accepted (s_ready=0).

Test Plan:
- 5x5 ramp frame 0..24, m_ready=1, s_valid=1 continuous -> exactly 25 windows in raster order:
  - (0,0) = {0,0,0, 0,0,1, 0,5,6}
  - (2,2) = {6,7,8, 11,12,13, 16,17,18}
  - (4,4) = {18,19,0, 23,24,0, 0,0,0} with m_last=1
  - o_done pulses once, one cycle after that handshake.
- Sobel-style frame (rows 0-2 = 255, rows 3-4 = 0) -> window (2,1) = {255,255,255, 255,255,255, 0,0,0}; window (3,0) = {0,255,255, 0,0,0, 0,0,0}.
- Random m_ready with ~50% duty -> m_* stable while stalled, no window lost or duplicated, s_ready drops once in_cnt reaches (orow+2)*5; 25 windows total.
- Gapped s_valid (1 pixel every 3 cycles) -> identical window sequence to the first scenario; m_valid never asserted before the eligibility rule is met.
- i_start pulsed during RUN, and s_valid high during IDLE -> no effect: no pixel accepted, window count unchanged.
- rst asserted after 12 pixels -> next cycle all outputs are 0. A following fresh frame produces a correct (0,0) window with no stale data.
